// File: rtl/som_sweep_if.sv
// Sweep-controller bus: host handshake, expected mask, results and evaluator drive/sense.
interface som_sweep_if;
  logic        start;
  logic [15:0] exp_mask;
  logic        f_in;
  logic        en_out;
  logic [3:0]  abcd;
  logic        busy;
  logic        done;
  logic [15:0] tt;
  logic [4:0]  err_cnt;
  logic        match;
  logic [3:0]  first_err_idx;

  modport slave (
    input  start, exp_mask, f_in,
    output en_out, abcd, busy, done, tt, err_cnt, match, first_err_idx
  );

  modport master (
    output start, exp_mask, f_in,
    input  en_out, abcd, busy, done, tt, err_cnt, match, first_err_idx
  );
endinterface

// File: rtl/som_sweep_ctrl.sv
// Walks minterms 0..15 through the sum-of-minterms evaluator, builds its truth table and grades it.
// Optional: define SOM_SWEEP_STOP_ON_ERR_EN to end the sweep at the first mismatching index.
module som_sweep_ctrl #(
  parameter int unsigned SETTLE = 1
) (
  input  logic        clk,
  input  logic        rst,
  som_sweep_if.slave  bus
);

  localparam int unsigned IdxW = 4;
  localparam int unsigned CntW = 4;
  localparam int unsigned ErrW = 5;
  localparam int unsigned TtW  = 16;

  typedef enum logic [1:0] {IDLE, DRIVE, SAMPLE, DONE} state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [IdxW-1:0]   abcd_q, abcd_d;
  logic [IdxW-1:0]   first_q, first_d;
  logic [TtW-1:0]    exp_q, exp_d;
  logic [TtW-1:0]    tt_q, tt_d;
  logic [ErrW-1:0]   err_q, err_d;
  logic              en_q, en_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              match_q, match_d;
  logic              mis_c;
  logic              last_c;

  assign mis_c = (bus.f_in != exp_q[abcd_q]);

  // Sweep ends after index 15, or at the first mismatch when early stop is built in.
`ifdef SOM_SWEEP_STOP_ON_ERR_EN
  assign last_c = (abcd_q == IdxW'(15)) || mis_c;
`else
  assign last_c = (abcd_q == IdxW'(15));
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    abcd_d  = abcd_q;
    first_d = first_q;
    exp_d   = exp_q;
    tt_d    = tt_q;
    err_d   = err_q;
    en_d    = en_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    match_d = match_q;

    unique case (state_q)
      IDLE: begin
        en_d = 1'b0;
        if (bus.start) begin
          exp_d   = bus.exp_mask;
          tt_d    = '0;
          err_d   = '0;
          first_d = '0;
          abcd_d  = '0;
          en_d    = 1'b1;
          busy_d  = 1'b1;
          cnt_d   = CntW'(SETTLE);
          state_d = DRIVE;
        end
      end

      DRIVE: begin
        cnt_d = cnt_q - CntW'(1);
        if (cnt_q == CntW'(1)) begin
          state_d = SAMPLE;
        end
      end

      SAMPLE: begin
        tt_d[abcd_q] = bus.f_in;
        if (mis_c) begin
          err_d = err_q + ErrW'(1);
          if (err_q == '0) begin
            first_d = abcd_q;
          end
        end
        if (last_c) begin
          // Grade includes this final sample, so match uses err_d.
          match_d = (err_d == '0);
          done_d  = 1'b1;
          en_d    = 1'b0;
          abcd_d  = '0;
          state_d = DONE;
        end else begin
          abcd_d  = abcd_q + IdxW'(1);
          cnt_d   = CntW'(SETTLE);
          state_d = DRIVE;
        end
      end

      DONE: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      abcd_q  <= '0;
      first_q <= '0;
      exp_q   <= '0;
      tt_q    <= '0;
      err_q   <= '0;
      en_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      match_q <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      abcd_q  <= abcd_d;
      first_q <= first_d;
      exp_q   <= exp_d;
      tt_q    <= tt_d;
      err_q   <= err_d;
      en_q    <= en_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      match_q <= match_d;
    end
  end

  assign bus.en_out        = en_q;
  assign bus.abcd          = abcd_q;
  assign bus.busy          = busy_q;
  assign bus.done          = done_q;
  assign bus.tt            = tt_q;
  assign bus.err_cnt       = err_q;
  assign bus.match         = match_q;
  assign bus.first_err_idx = first_q;

endmodule
